// File: rtl/ctrl_packet_dispatcher.sv
// Control packet dispatcher: FIFO-buffered decode and one-hot per-unit command issue with SYNC barrier.
// Define DISPATCH_STATS_EN to enable the issued_count / err_count statistics counters.
module ctrl_packet_dispatcher #(
  parameter int unsigned NUM_UNITS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [13:0]          pkt_data,
  output logic [NUM_UNITS-1:0] unit_cmd_valid,
  input  logic [NUM_UNITS-1:0] unit_cmd_ready,
  output logic [2:0]           unit_op,
  output logic [2:0]           unit_comp,
  input  logic [NUM_UNITS-1:0] unit_busy,
  output logic                 sync_done,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [15:0]          issued_count,
  output logic [7:0]           err_count
);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  OP_NOP   = 3'd0;
  localparam logic [2:0]  OP_COMP  = 3'd3;
  localparam logic [2:0]  OP_SYNC  = 3'd4;

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_SYNC_WAIT} state_t;

  // Reserved bits are never stored; only unit_id/op_code/comp_type go into the FIFO.
  logic [9:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;
  logic                 r_pkt_ready;
  state_t               r_state;
  logic [NUM_UNITS-1:0] r_cmd_valid;
  logic [2:0]           r_op;
  logic [2:0]           r_comp;
  logic                 r_sync_done;
  logic                 r_err_valid;
  logic [1:0]           r_err_code;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_hs;
  logic [9:0]           w_head;
  logic [3:0]           w_uid;
  logic [2:0]           w_op;
  logic [2:0]           w_comp;
  logic [NUM_UNITS-1:0] w_onehot;
  logic [AW:0]          w_count_nxt;
  logic                 w_unused_rsvd;

  assign w_unused_rsvd = ^pkt_data[3:0];
  assign w_push = pkt_valid & r_pkt_ready;
  assign w_pop  = (r_state == D_IDLE) && (r_count != '0);
  assign w_hs   = |(r_cmd_valid & unit_cmd_ready);
  assign w_head = r_mem[r_rptr];
  assign w_uid  = w_head[9:6];
  assign w_op   = w_head[5:3];
  assign w_comp = w_head[2:0];

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      w_onehot[i] = (32'(w_uid) == i);
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + (AW+1)'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= pkt_data[13:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_pkt_ready <= 1'b0;
      r_state     <= D_IDLE;
      r_cmd_valid <= '0;
      r_op        <= '0;
      r_comp      <= '0;
      r_sync_done <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_pkt_ready <= (w_count_nxt != FULL_CNT);
      r_sync_done <= 1'b0;
      r_err_valid <= 1'b0;
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case (r_state)
        D_IDLE: begin
          if (w_pop) begin
            // NOP and SYNC are mutually exclusive, so testing SYNC ahead of the unit_id check keeps decode priority.
            if (w_op > OP_SYNC) begin
              r_err_valid <= 1'b1;
              r_err_code  <= 2'b10;
            end else if (w_op == OP_SYNC) begin
              r_state <= D_SYNC_WAIT;
            end else if (w_op != OP_NOP) begin
              if (32'(w_uid) >= NUM_UNITS) begin
                r_err_valid <= 1'b1;
                r_err_code  <= 2'b01;
              end else if (w_op == OP_COMP && w_comp > 3'd3) begin
                r_err_valid <= 1'b1;
                r_err_code  <= 2'b11;
              end else begin
                r_cmd_valid <= w_onehot;
                r_op        <= w_op;
                r_comp      <= w_comp;
                r_state     <= D_ISSUE;
              end
            end
          end
        end
        D_ISSUE: begin
          if (w_hs) begin
            r_cmd_valid <= '0;
            r_op        <= '0;
            r_comp      <= '0;
            r_state     <= D_IDLE;
          end
        end
        D_SYNC_WAIT: begin
          if (unit_busy == '0) begin
            r_sync_done <= 1'b1;
            r_state     <= D_IDLE;
          end
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] r_issued;
  logic [7:0]  r_errs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= '0;
      r_errs   <= '0;
    end else begin
      if (w_hs)
        r_issued <= r_issued + 16'd1;
      if (r_err_valid && r_errs != '1)
        r_errs <= r_errs + 8'd1;
    end
  end

  assign issued_count = r_issued;
  assign err_count    = r_errs;
`else
  assign issued_count = '0;
  assign err_count    = '0;
`endif

  assign pkt_ready      = r_pkt_ready;
  assign unit_cmd_valid = r_cmd_valid;
  assign unit_op        = r_op;
  assign unit_comp      = r_comp;
  assign sync_done      = r_sync_done;
  assign err_valid      = r_err_valid;
  assign err_code       = r_err_code;

endmodule

// File: tb/tb_ctrl_packet_dispatcher.sv
// Bench for ctrl_packet_dispatcher: directed timing steps plus randomized traffic checked
// against a transaction-level event model.
`timescale 1ns/1ps
module tb_ctrl_packet_dispatcher;
  localparam int unsigned NU      = 4;
  localparam int unsigned EV_CMD  = 32'h100;
  localparam int unsigned EV_ERR  = 32'h200;
  localparam int unsigned EV_SYNC = 32'h300;
`ifdef DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic [13:0] pkt_data = '0;
  logic        pkt_ready;
  logic [3:0]  unit_cmd_valid;
  logic [3:0]  unit_cmd_ready;
  logic [2:0]  unit_op;
  logic [2:0]  unit_comp;
  logic [3:0]  unit_busy;
  logic        sync_done;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] issued_count;
  logic [7:0]  err_count;

  bit          rand_mode = 1'b0;
  logic [3:0]  dir_ready = '0;
  logic [3:0]  dir_busy = '0;
  logic [3:0]  rnd_ready = '0;
  logic [3:0]  rnd_busy = '0;
  int unsigned bcnt [4];

  int unsigned exp_q[$];
  int unsigned obs_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_iss = 0;
  int unsigned exp_errs = 0;
  int unsigned mon_idx;

  assign unit_cmd_ready = rand_mode ? rnd_ready : dir_ready;
  assign unit_busy      = rand_mode ? rnd_busy  : dir_busy;

  always #5 clk = ~clk;

  ctrl_packet_dispatcher #(.NUM_UNITS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .unit_cmd_valid(unit_cmd_valid), .unit_cmd_ready(unit_cmd_ready),
    .unit_op(unit_op), .unit_comp(unit_comp), .unit_busy(unit_busy),
    .sync_done(sync_done), .err_valid(err_valid), .err_code(err_code),
    .issued_count(issued_count), .err_count(err_count)
  );

  // Random unit behaviour: busy for a few cycles starting right after each handshake.
  always @(posedge clk) begin
    logic [3:0] hs;
    hs = unit_cmd_valid & unit_cmd_ready;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) bcnt[i] = $urandom_range(1, 6);
      else if (bcnt[i] != 0) bcnt[i] = bcnt[i] - 1;
      rnd_busy[i] = (bcnt[i] != 0);
    end
    rnd_ready = 4'($urandom);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if ((unit_cmd_valid & unit_cmd_ready) != 4'b0) begin
        mon_idx = 0;
        for (int i = 0; i < 4; i++) if (unit_cmd_valid[i]) mon_idx = i;
        if ($countones(unit_cmd_valid) == 1)
          obs_q.push_back(EV_CMD | (mon_idx << 6) | (32'(unit_op) << 3) | 32'(unit_comp));
        else
          obs_q.push_back(32'hFFF);
      end
      if (err_valid) obs_q.push_back(EV_ERR | 32'(err_code));
      if (sync_done) obs_q.push_back(EV_SYNC);
    end
  end

  function automatic int unsigned decode(input logic [13:0] d);
    int unsigned uid, op, comp;
    uid = 32'(d[13:10]);
    op = 32'(d[9:7]);
    comp = 32'(d[6:4]);
    if (op >= 5) return EV_ERR | 2;
    if (op == 0) return 0;
    if (op == 4) return EV_SYNC;
    if (uid >= NU) return EV_ERR | 1;
    if (op == 3 && comp > 3) return EV_ERR | 3;
    return EV_CMD | (uid << 6) | (op << 3) | comp;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [13:0] d);
    int unsigned ev;
    ev = decode(d);
    if (ev != 0) exp_q.push_back(ev);
    if ((ev >> 8) == 1) exp_iss++;
    if ((ev >> 8) == 2 && exp_errs < 255) exp_errs++;
  endtask

  task automatic send(input logic [13:0] d);
    bit done;
    done = 1'b0;
    pkt_valid = 1'b1;
    pkt_data = d;
    for (int k = 0; k < 200 && !done; k++) begin
      if (pkt_ready) begin
        accept(d);
        done = 1'b1;
      end
      tick();
    end
    pkt_valid = 1'b0;
    chk("send_accept", 32'(done), 1);
  endtask

  task automatic drain_and_compare(input string tag);
    for (int k = 0; k < 4000 && obs_q.size() < exp_q.size(); k++) tick();
    repeat (6) tick();
    chk({tag, "_event_count"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk({tag, "_event"}, obs_q[k], exp_q[k]);
    chk({tag, "_issued_count"}, 32'(issued_count), STATS ? exp_iss : 0);
    chk({tag, "_err_count"}, 32'(err_count), STATS ? exp_errs : 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [13:0] pk [5];
    logic [13:0] e [3];
    logic [1:0]  ecode [3];
    int unsigned idx;
    bit rdy;

    repeat (3) tick();
    chk("rst_pkt_ready", 32'(pkt_ready), 0);
    chk("rst_cmd_valid", 32'(unit_cmd_valid), 0);
    chk("rst_unit_op", 32'(unit_op), 0);
    chk("rst_unit_comp", 32'(unit_comp), 0);
    chk("rst_sync_done", 32'(sync_done), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_issued", 32'(issued_count), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_ready", 32'(pkt_ready), 1);

    // LOAD to unit 2 with ready tied high
    dir_ready = '1;
    send({4'd2, 3'd1, 3'd0, 4'd0});
    chk("load_not_yet", 32'(unit_cmd_valid), 0);
    tick();
    chk("load_valid", 32'(unit_cmd_valid), 32'b0100);
    chk("load_op", 32'(unit_op), 1);
    tick();
    chk("load_one_cycle", 32'(unit_cmd_valid), 0);
    drain_and_compare("load");

    // COMP/TANH to unit 1 held for 6 cycles while the FIFO fills
    dir_ready = '0;
    pk[0] = {4'd0, 3'd1, 3'd2, 4'd3};
    pk[1] = {4'd3, 3'd2, 3'd5, 4'd0};
    pk[2] = {4'd2, 3'd3, 3'd1, 4'd9};
    pk[3] = {4'd1, 3'd1, 3'd7, 4'd0};
    pk[4] = {4'd2, 3'd2, 3'd0, 4'd0};
    send({4'd1, 3'd3, 3'd2, 4'hA});
    idx = 0;
    pkt_valid = 1'b1;
    pkt_data = pk[0];
    for (int t = 1; t <= 6; t++) begin
      rdy = pkt_ready;
      tick();
      if (rdy && idx < 5) begin
        accept(pk[idx]);
        idx++;
        if (idx < 5) pkt_data = pk[idx];
        else pkt_valid = 1'b0;
      end
      chk("comp_hold_valid", 32'(unit_cmd_valid), 32'b0010);
      chk("comp_hold_op", 32'(unit_op), 3);
      chk("comp_hold_comp", 32'(unit_comp), 2);
      if (t == 3) chk("fifo_three_ready", 32'(pkt_ready), 1);
      if (t == 4) chk("fifo_full_ready", 32'(pkt_ready), 0);
    end
    pkt_valid = 1'b0;
    chk("comp_queued", idx, 4);
    dir_ready = 4'b0010;
    tick();
    chk("comp_handshake", 32'(unit_cmd_valid), 0);
    dir_ready = '1;
    for (int j = idx; j < 5; j++) send(pk[j]);
    drain_and_compare("comp");

    // back-to-back rejects
    e[0] = {4'd7, 3'd1, 3'd0, 4'd0};
    e[1] = {4'd0, 3'd6, 3'd0, 4'd0};
    e[2] = {4'd0, 3'd3, 3'd5, 4'd0};
    ecode[0] = 2'b01;
    ecode[1] = 2'b10;
    ecode[2] = 2'b11;
    pkt_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      pkt_data = e[j];
      chk("err_ready", 32'(pkt_ready), 1);
      accept(e[j]);
      tick();
      if (j > 0) begin
        chk("err_pulse", 32'(err_valid), 1);
        chk("err_code", 32'(err_code), 32'(ecode[j-1]));
      end
      chk("err_no_cmd", 32'(unit_cmd_valid), 0);
    end
    pkt_valid = 1'b0;
    tick();
    chk("err_pulse_last", 32'(err_valid), 1);
    chk("err_code_last", 32'(err_code), 3);
    tick();
    chk("err_pulse_end", 32'(err_valid), 0);
    drain_and_compare("err");

    // STORE to unit 0 followed by a SYNC barrier
    send({4'd0, 3'd2, 3'd4, 4'd0});
    send({4'd5, 3'd4, 3'd0, 4'd0});
    chk("store_valid", 32'(unit_cmd_valid), 32'b0001);
    tick();
    dir_busy = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("sync_wait_quiet", 32'(sync_done), 0);
    end
    dir_busy = '0;
    chk("sync_not_early", 32'(sync_done), 0);
    tick();
    chk("sync_pulse", 32'(sync_done), 1);
    tick();
    chk("sync_pulse_end", 32'(sync_done), 0);
    drain_and_compare("sync");

    // reset while a command is in flight with packets queued
    dir_ready = '0;
    send({4'd3, 3'd1, 3'd1, 4'd0});
    send({4'd0, 3'd1, 3'd2, 4'd0});
    send({4'd1, 3'd2, 3'd3, 4'd0});
    send({4'd2, 3'd3, 3'd0, 4'd0});
    chk("pre_rst_valid", 32'(unit_cmd_valid), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("midrst_pkt_ready", 32'(pkt_ready), 0);
    chk("midrst_cmd_valid", 32'(unit_cmd_valid), 0);
    chk("midrst_unit_op", 32'(unit_op), 0);
    chk("midrst_unit_comp", 32'(unit_comp), 0);
    obs_q.delete();
    exp_q.delete();
    exp_iss = 0;
    exp_errs = 0;
    tick();
    rst_n = 1'b1;
    dir_ready = '1;
    repeat (10) tick();
    chk("post_rst_ready", 32'(pkt_ready), 1);
    chk("post_rst_no_events", obs_q.size(), 0);
    drain_and_compare("post_rst");

    // randomized traffic with random unit readiness and busy
    rand_mode = 1'b1;
    for (int n = 0; n < 250; n++) begin
      send({4'($urandom_range(0, 5)), 3'($urandom), 3'($urandom), 4'($urandom)});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    drain_and_compare("rand");
    rand_mode = 1'b0;

    // enough rejects to reach the reject-counter ceiling
    dir_ready = '1;
    for (int n = 0; n < 260; n++) send({4'($urandom), 3'd7, 3'($urandom), 4'd0});
    drain_and_compare("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
